pipe_field: RTL and testbench

PIPE_FIELD -- requirements
Module: pipe_field

---
 rtl/flappy_pkg.sv | 27 ++
 rtl/flappy_lfsr.sv | 29 ++
 rtl/pipe_field.sv | 216 +++++++++++++++++++++
 tb/tb_pipe_field.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// flappy_pkg: screen geometry, gap limits and the per-pipe state record
// shared by the pipe field and its helpers.
package flappy_pkg;

  localparam int SCREEN_W     = 800;
  localparam int SCREEN_H     = 480;

  localparam int GAP_MIN_TOP  = 60;
  localparam int GAP_MAX_TOP  = 320;
  localparam int GAP_MIN_SIZE = 110;
  localparam int GAP_MAX_SIZE = 150;

  // One scrolling pipe: left edge plus the open gap (top row and height).
  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  gap_top;
    logic [8:0]  gap_size;
  } pipe_state_t;

  // Rotate a 10-bit value left by n positions.
  function automatic logic [9:0] rotl10(input logic [9:0] v, input int n);
    logic [19:0] dbl;
    dbl = {v, v} >> (10 - (n % 10));
    return dbl[9:0];
  endfunction

endpackage

// File: rtl/flappy_lfsr.sv
// flappy_lfsr: Fibonacci LFSR that shifts only when i_step is high.
// Default taps give the maximal-length polynomial x^10 + x^7 + 1.
module flappy_lfsr #(
  parameter int               WIDTH  = 10,
  parameter logic [WIDTH-1:0] SEED   = '1,
  parameter int               TAP_HI = WIDTH - 1,
  parameter int               TAP_LO = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH-1:0] r_state;

  // Advance one position per step; hold otherwise.
  // NOTE: clocked state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SEED;
    end else if (i_step) begin
      r_state <= {r_state[WIDTH-2:0], r_state[TAP_HI] ^ r_state[TAP_LO]};
    end
  end

  assign o_value = r_state;

endmodule

// File: rtl/pipe_field.sv
// pipe_field: a row of independently scrolling pipes with random gaps.
// Provides a zero-latency pixel mask, a registered bird collision flag and a
// one-cycle pulse whenever a pipe slides past the bird.
// Optional build macro: PIPE_FIELD_RAMP_EN -- speed rises by one every eight
// passed pipes, saturating at 4; without it the speed is fixed at 1.
module pipe_field #(
  parameter int         NUM_PIPES    = 4,
  parameter int         PIPE_WIDTH   = 40,
  parameter int         PIPE_SPACING = 220,
  parameter int         STEP_DIV     = 1_000_000,
  parameter int         SCREEN_W     = flappy_pkg::SCREEN_W,
  parameter int         GAP_MIN_TOP  = flappy_pkg::GAP_MIN_TOP,
  parameter int         GAP_MAX_TOP  = flappy_pkg::GAP_MAX_TOP,
  parameter int         GAP_MIN_SIZE = flappy_pkg::GAP_MIN_SIZE,
  parameter int         GAP_MAX_SIZE = flappy_pkg::GAP_MAX_SIZE,
  parameter logic [9:0] LFSR_SEED    = 10'h3FF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic [9:0] bird_x,
  input  logic [9:0] bird_y,
  input  logic [4:0] bird_w,
  input  logic [4:0] bird_h,
  output logic       pipe_pixel,
  output logic       pipe_collision,
  output logic       pipe_passed,
  output logic [2:0] speed
);

  import flappy_pkg::*;

  localparam int          RESPAWN_X = SCREEN_W + 80;
  localparam int          CNT_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned TOP_SPAN  = GAP_MAX_TOP - GAP_MIN_TOP + 1;
  localparam int unsigned SIZE_SPAN = GAP_MAX_SIZE - GAP_MIN_SIZE + 1;

  pipe_state_t      r_pipe [NUM_PIPES];
  pipe_state_t      w_next [NUM_PIPES];
  logic [CNT_W-1:0] r_step_cnt;
  logic             r_passed;
  logic             r_collision;
  logic             w_step;
  logic [9:0]       w_lfsr;
  logic [2:0]       w_speed;
  logic [NUM_PIPES-1:0] w_pass;
  logic [10:0]      w_max_other [NUM_PIPES];
  logic [11:0]      w_spawn_sum [NUM_PIPES];
  logic [10:0]      w_respawn_x [NUM_PIPES];
  logic [9:0]       w_gap_top   [NUM_PIPES];
  logic [8:0]       w_gap_size  [NUM_PIPES];
  logic             w_pixel;
  logic             w_hit;
  logic [10:0]      w_hc;
  logic [10:0]      w_vc;
  logic [10:0]      w_bx;
  logic [10:0]      w_by;
  logic [10:0]      w_bx_end;
  logic [10:0]      w_by_end;

  assign w_step = enable && (r_step_cnt == CNT_W'(STEP_DIV - 1));

  // Free-running step divider, frozen while the game is paused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step_cnt <= '0;
    end else if (enable) begin
      r_step_cnt <= w_step ? '0 : r_step_cnt + 1'b1;
    end
  end

  flappy_lfsr #(
    .WIDTH (10),
    .SEED  (LFSR_SEED),
    .TAP_HI(9),
    .TAP_LO(6)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .i_step (w_step),
    .o_value(w_lfsr)
  );

  // Per-channel gap draw: each channel sees a different rotation of the LFSR.
  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_gap
    logic [9:0] w_rot;
    logic [6:0] w_sel;
    assign w_rot         = rotl10(w_lfsr, g);
    assign w_sel         = w_lfsr[9:3] ^ 7'(g);
    assign w_gap_top[g]  = 10'(GAP_MIN_TOP) + 10'(32'(w_rot) % TOP_SPAN);
    assign w_gap_size[g] = 9'(GAP_MIN_SIZE) + 9'(32'(w_sel) % SIZE_SPAN);
  end

  // Respawn position: behind the furthest other pipe, never closer than RESPAWN_X.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < NUM_PIPES; i++) begin
      w_max_other[i] = '0;
      for (int j = 0; j < NUM_PIPES; j++) begin
        if (j != i && r_pipe[j].x > w_max_other[i]) begin
          w_max_other[i] = r_pipe[j].x;
        end
      end
      w_spawn_sum[i] = 12'(w_max_other[i]) + 12'(PIPE_SPACING);
      w_respawn_x[i] = (w_spawn_sum[i] < 12'(RESPAWN_X)) ? 11'(RESPAWN_X)
                                                        : w_spawn_sum[i][10:0];
    end
  end

  // Next channel state on a step, and whether that step carries it past the bird.
  always_comb begin
    for (int i = 0; i < NUM_PIPES; i++) begin
      w_next[i] = r_pipe[i];
      if (r_pipe[i].x > 11'(w_speed)) begin
        w_next[i].x = r_pipe[i].x - 11'(w_speed);
      end else begin
        w_next[i].x        = w_respawn_x[i];
        w_next[i].gap_top  = w_gap_top[i];
        w_next[i].gap_size = w_gap_size[i];
      end
      w_pass[i] = ((12'(r_pipe[i].x) + 12'(PIPE_WIDTH)) >  12'(bird_x)) &&
                  ((12'(w_next[i].x) + 12'(PIPE_WIDTH)) <= 12'(bird_x));
    end
  end

  // Channel registers: move or respawn on each step, hold otherwise.
  // NOTE: the channel array is only a few flops, not a RAM, so it takes a full reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_pipe[i].x        <= 11'(RESPAWN_X + i * PIPE_SPACING);
        r_pipe[i].gap_top  <= 10'(GAP_MIN_TOP + 60 * (i % 5));
        r_pipe[i].gap_size <= 9'(GAP_MIN_SIZE + 10 * (i % 5));
      end
    end else if (w_step) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_pipe[i] <= w_next[i];
      end
    end
  end

  // One pulse per step however many channels pass on it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_passed <= 1'b0;
    end else begin
      r_passed <= w_step && (|w_pass);
    end
  end

  assign w_hc     = {1'b0, hCount};
  assign w_vc     = {1'b0, vCount};
  assign w_bx     = {1'b0, bird_x};
  assign w_by     = {1'b0, bird_y};
  assign w_bx_end = {1'b0, bird_x} + 11'(bird_w);
  assign w_by_end = {1'b0, bird_y} + 11'(bird_h);

  // Solid-region tests for the scan position and the bird box; off-screen pipes are ignored.
  always_comb begin
    w_pixel = 1'b0;
    w_hit   = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (r_pipe[i].x < 11'(SCREEN_W)) begin
        if ((w_hc >= r_pipe[i].x) && (w_hc < r_pipe[i].x + 11'(PIPE_WIDTH)) &&
            !((w_vc >= 11'(r_pipe[i].gap_top)) &&
              (w_vc < 11'(r_pipe[i].gap_top) + 11'(r_pipe[i].gap_size)))) begin
          w_pixel = 1'b1;
        end
        if ((w_bx < r_pipe[i].x + 11'(PIPE_WIDTH)) && (w_bx_end > r_pipe[i].x) &&
            ((w_by < 11'(r_pipe[i].gap_top)) ||
             (w_by_end > 11'(r_pipe[i].gap_top) + 11'(r_pipe[i].gap_size)))) begin
          w_hit = 1'b1;
        end
      end
    end
  end

  // Collision is sampled every cycle, paused or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_collision <= 1'b0;
    end else begin
      r_collision <= w_hit;
    end
  end

`ifdef PIPE_FIELD_RAMP_EN
  logic [2:0] r_pass_cnt;
  logic [2:0] r_speed;

  // Every eighth pass bumps the speed, up to 4 pixels per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pass_cnt <= '0;
      r_speed    <= 3'd1;
    end else if (r_passed) begin
      r_pass_cnt <= r_pass_cnt + 3'd1;
      if (r_pass_cnt == 3'd7 && r_speed < 3'd4) begin
        r_speed <= r_speed + 3'd1;
      end
    end
  end

  assign w_speed = r_speed;
`else
  assign w_speed = 3'd1;
`endif

  assign pipe_pixel     = w_pixel;
  assign pipe_collision = r_collision;
  assign pipe_passed    = r_passed;
  assign speed          = w_speed;

endmodule

// File: tb/tb_pipe_field.sv
// tb_pipe_field: randomized scoreboard bench for pipe_field with a
// behavioural model of the scrolling field (STEP_DIV shortened to 4).
module tb_pipe_field;

  localparam int NP   = 4;
  localparam int PW   = 40;
  localparam int PS   = 220;
  localparam int SD   = 4;
  localparam int SW   = 800;
  localparam int RX   = SW + 80;
  localparam int GMT  = 60;
  localparam int GXT  = 320;
  localparam int GMS  = 110;
  localparam int GXS  = 150;
  localparam int N_IT = 30000;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [9:0] hCount, vCount, bird_x, bird_y;
  logic [4:0] bird_w, bird_h;
  logic       pipe_pixel, pipe_collision, pipe_passed;
  logic [2:0] speed;

  always #5 clk = ~clk;

  pipe_field #(
    .NUM_PIPES(NP), .PIPE_WIDTH(PW), .PIPE_SPACING(PS), .STEP_DIV(SD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .hCount(hCount), .vCount(vCount),
    .bird_x(bird_x), .bird_y(bird_y), .bird_w(bird_w), .bird_h(bird_h),
    .pipe_pixel(pipe_pixel), .pipe_collision(pipe_collision),
    .pipe_passed(pipe_passed), .speed(speed)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_x [NP];
  int m_top [NP];
  int m_size [NP];
  int m_lfsr, m_cnt, m_npass;
  bit m_passed, m_coll;

  function automatic int lfsr_next(input int l);
    int fb;
    fb = $countones(l & 'h240) % 2;
    return ((l << 1) | fb) & 'h3FF;
  endfunction

  function automatic int rotl(input int l, input int r);
    return ((l << r) | (l >> (10 - r))) & 'h3FF;
  endfunction

  function automatic int model_speed();
`ifdef PIPE_FIELD_RAMP_EN
    int s;
    s = 1 + m_npass / 8;
    return (s > 4) ? 4 : s;
`else
    return 1;
`endif
  endfunction

  function automatic bit rect_hit(input int ax0, ax1, ay0, ay1, bx0, bx1, by0, by1);
    return (ax0 < bx1) && (bx0 < ax1) && (ay0 < by1) && (by0 < ay1);
  endfunction

  function automatic bit model_collide(input int bx, by, bw, bh);
    bit r = 0;
    for (int c = 0; c < NP; c++) begin
      if (m_x[c] < SW) begin
        if (rect_hit(bx, bx + bw, by, by + bh, m_x[c], m_x[c] + PW, 0, m_top[c])) r = 1;
        if (rect_hit(bx, bx + bw, by, by + bh, m_x[c], m_x[c] + PW,
                     m_top[c] + m_size[c], 4096)) r = 1;
      end
    end
    return r;
  endfunction

  function automatic bit model_pixel(input int h, input int v);
    bit r = 0;
    for (int c = 0; c < NP; c++) begin
      if (m_x[c] < SW && h >= m_x[c] && h < m_x[c] + PW &&
          (v < m_top[c] || v >= m_top[c] + m_size[c])) r = 1;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NP; c++) begin
      m_x[c]    = RX + c * PS;
      m_top[c]  = GMT + 60 * (c % 5);
      m_size[c] = GMS + 10 * (c % 5);
    end
    m_lfsr = 'h3FF; m_cnt = 0; m_npass = 0; m_passed = 0; m_coll = 0;
  endtask

  // One clock edge, using the inputs held during the cycle that just ended.
  task automatic model_edge();
    int  spd, pre [NP], mo, nx;
    bit  step, pass;
    spd    = model_speed();
    m_coll = model_collide(int'(bird_x), int'(bird_y), int'(bird_w), int'(bird_h));
    if (m_passed) m_npass++;
    step = 0;
    pass = 0;
    if (enable) begin
      if (m_cnt == SD - 1) begin m_cnt = 0; step = 1; end
      else m_cnt++;
    end
    if (step) begin
      for (int c = 0; c < NP; c++) pre[c] = m_x[c];
      for (int c = 0; c < NP; c++) begin
        if (pre[c] > spd) m_x[c] = pre[c] - spd;
        else begin
          mo = 0;
          for (int o = 0; o < NP; o++) if (o != c && pre[o] > mo) mo = pre[o];
          nx = mo + PS;
          m_x[c]    = (nx < RX) ? RX : nx;
          m_top[c]  = GMT + rotl(m_lfsr, c) % (GXT - GMT + 1);
          m_size[c] = GMS + (((m_lfsr >> 3) ^ c) % (GXS - GMS + 1));
        end
        if (pre[c] + PW > int'(bird_x) && m_x[c] + PW <= int'(bird_x)) pass = 1;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
    m_passed = pass;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    int                    cyc;
    bit                    pix;
    bit                    coll;
    logic [2:0]            spd;
    logic [NP-1:0][10:0]   xs;
    logic [NP-1:0][9:0]    tops;
    logic [NP-1:0][8:0]    sizes;
    logic [9:0]            lfsr;
  } exp_t;

  exp_t exp_q [$];
  int   pass_q [$];

  // Monitor: one expectation per cycle, plus the pass-pulse event queue.
  initial begin
    exp_t e;
    int   pc;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pipe_pixel", 32'(pipe_pixel), 32'(e.pix));
        check("pipe_collision", 32'(pipe_collision), 32'(e.coll));
        check("speed", 32'(speed), 32'(e.spd));
        check("lfsr", 32'(dut.w_lfsr), 32'(e.lfsr));
        for (int i = 0; i < NP; i++) begin
          check($sformatf("x[%0d]", i), 32'(dut.r_pipe[i].x), 32'(e.xs[i]));
          check($sformatf("gap_top[%0d]", i), 32'(dut.r_pipe[i].gap_top), 32'(e.tops[i]));
          check($sformatf("gap_size[%0d]", i), 32'(dut.r_pipe[i].gap_size), 32'(e.sizes[i]));
        end
        if (pipe_passed) begin
          if (pass_q.size() == 0) check("pass_unexpected", 1, 0);
          else begin
            pc = pass_q.pop_front();
            check("pass_cycle", 32'(e.cyc), 32'(pc));
          end
        end else if (pass_q.size() != 0 && pass_q[0] <= e.cyc) begin
          pc = pass_q.pop_front();
          check("pass_missed", 0, 1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int   rel_it   = 2;
    int   pause_it = 9000;
    int   rst_hold = 0;
    int   rst_rel  = -10;
    bit   rst_done = 0;
    int   snap_x [NP];
    int   snap_l, c, v;
    exp_t e;

    reset = 1'b1; enable = 1'b0;
    hCount = '0; vCount = '0;
    bird_x = 10'd100; bird_y = 10'd200; bird_w = 5'd16; bird_h = 5'd12;
    model_reset();

    for (int it = 0; it < N_IT; it++) begin
      @(posedge clk);
      #1;
      if (reset) model_reset();
      else model_edge();

      if (it == rel_it + 4) check("x0_first_step", 32'(dut.r_pipe[0].x), 879);
      if (it == rel_it + 8) check("x0_second_step", 32'(dut.r_pipe[0].x), 878);
      if (it == pause_it) begin
        for (int i = 0; i < NP; i++) snap_x[i] = m_x[i];
        snap_l = m_lfsr;
      end
      if (it == pause_it + 100) begin
        for (int i = 0; i < NP; i++)
          check($sformatf("pause_x[%0d]", i), 32'(dut.r_pipe[i].x), 32'(snap_x[i]));
        check("pause_lfsr", 32'(dut.w_lfsr), 32'(snap_l));
      end
      if (it == rst_rel + 1) begin
        check("speed_after_reset", 32'(speed), 1);
        check("x0_after_reset", 32'(dut.r_pipe[0].x), RX);
      end

      // Reset control: initial release, then one reset mid-way through a step count.
      if (it == rel_it) reset = 1'b0;
      if (!rst_done && it >= 20000 && m_cnt == 2 && enable) begin
        reset = 1'b1; model_reset(); rst_done = 1; rst_hold = 3;
      end else if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) begin reset = 1'b0; rst_rel = it; end
      end

      if (m_passed) pass_q.push_back(it);

      // Next cycle's inputs.
      if (it < rel_it) enable = 1'b0;
      else if (it < rel_it + 12) enable = 1'b1;
      else if (it >= pause_it && it < pause_it + 100) enable = 1'b0;
      else enable = ($urandom_range(0, 9) != 0);

      if ($urandom_range(0, 699) == 0) bird_x = 10'($urandom_range(60, 500));
      bird_w = 5'($urandom_range(1, 31));
      bird_h = 5'($urandom_range(1, 31));
      c = int'($urandom_range(0, NP - 1));
      if ($urandom_range(0, 1) == 1) begin
        v = m_top[c] + int'($urandom_range(0, 6)) - 3;
        if ($urandom_range(0, 1) == 1) v = m_top[c] + m_size[c] - int'(bird_h) + int'($urandom_range(0, 6)) - 3;
        bird_y = 10'((v < 0) ? 0 : v);
      end else bird_y = 10'($urandom_range(0, 460));

      if ($urandom_range(0, 1) == 1) begin
        v = m_x[c] + int'($urandom_range(0, 43)) - 2;
        hCount = 10'((v < 0) ? 0 : ((v > 1023) ? 1023 : v));
      end else hCount = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) begin
        v = ($urandom_range(0, 1) == 1) ? m_top[c] : m_top[c] + m_size[c];
        v = v + int'($urandom_range(0, 2)) - 1;
        vCount = 10'(v);
      end else vCount = 10'($urandom_range(0, 479));

      e.cyc  = it;
      e.pix  = model_pixel(int'(hCount), int'(vCount));
      e.coll = m_coll;
      e.spd  = 3'(model_speed());
      e.lfsr = 10'(m_lfsr);
      for (int i = 0; i < NP; i++) begin
        e.xs[i]    = 11'(m_x[i]);
        e.tops[i]  = 10'(m_top[i]);
        e.sizes[i] = 9'(m_size[i]);
      end
      exp_q.push_back(e);
    end

    repeat (2) @(negedge clk);
    while (pass_q.size() != 0) begin
      void'(pass_q.pop_front());
      check("pass_missed_end", 0, 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
